dmem_arbiter: RTL and testbench

- Shares the single port of the 2048x32 data RAM between two requesters: the CPU load/store stage and the program/debug loader.
- Adds a clear sequencer that zeroes the whole RAM, one word per cycle, on command.
- Sits between the requesters and the data RAM, and drives the RAM's addr/dataIn/wen inputs.
- The RAM read is asynchronous; the RAM write happens on the posedge when wen is high.

---
 rtl/dmem_arbiter_if.sv | 51 +++++
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-RAM requesters, the clear control, and the RAM port.
// The arbiter takes the slave modport; the requesters/RAM side take the master modport.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic              ldr_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_rvalid,
        output rdata,
        input  clr_start,
        output clr_busy, clr_done,
        output mem_addr, mem_wdata, mem_wen,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_rvalid,
        input  rdata,
        output clr_start,
        input  clr_busy, clr_done,
        input  mem_addr, mem_wdata, mem_wen,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-RAM port arbiter (CPU vs loader, round-robin) with a whole-RAM clear sequencer.
// Define DMEM_ARB_CPU_PRIO_EN to make the CPU win every contention instead of round-robin.
module dmem_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2048
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic { IDLE, CLEAR } state_t;
    typedef enum logic { GNT_CPU, GNT_LDR } owner_t;

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    state_t            state, state_nxt;
    owner_t            last_gnt, last_gnt_nxt;
    logic [ADDR_W:0]   clr_cnt, clr_cnt_nxt;
    logic [ADDR_W-1:0] addr_q, mem_addr_c;
    logic [DATA_W-1:0] wdata_q, mem_wdata_c;
    logic              mem_wen_c;
    logic              cpu_sel, ldr_sel, cpu_first, clr_last;

`ifdef DMEM_ARB_CPU_PRIO_EN
    assign cpu_first = 1'b1;
`else
    assign cpu_first = (last_gnt == GNT_LDR);
`endif

    // Next state, grants and the RAM-side mux; the RAM port holds its last address/data when idle.
    always_comb begin
        state_nxt    = state;
        clr_cnt_nxt  = clr_cnt;
        last_gnt_nxt = last_gnt;
        cpu_sel      = 1'b0;
        ldr_sel      = 1'b0;
        clr_last     = 1'b0;
        mem_addr_c   = addr_q;
        mem_wdata_c  = wdata_q;
        mem_wen_c    = 1'b0;
        if (rst) begin
            mem_addr_c  = '0;
            mem_wdata_c = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_start) begin
                        state_nxt   = CLEAR;
                        clr_cnt_nxt = '0;
                    end else if (bus.cpu_req && (!bus.ldr_req || cpu_first)) begin
                        cpu_sel      = 1'b1;
                        last_gnt_nxt = GNT_CPU;
                        mem_addr_c   = bus.cpu_addr;
                        mem_wdata_c  = bus.cpu_wdata;
                        mem_wen_c    = bus.cpu_we;
                    end else if (bus.ldr_req) begin
                        ldr_sel      = 1'b1;
                        last_gnt_nxt = GNT_LDR;
                        mem_addr_c   = bus.ldr_addr;
                        mem_wdata_c  = bus.ldr_wdata;
                        mem_wen_c    = bus.ldr_we;
                    end
                end
                CLEAR: begin
                    mem_addr_c  = clr_cnt[ADDR_W-1:0];
                    mem_wdata_c = '0;
                    mem_wen_c   = 1'b1;
                    if (clr_cnt == LAST_CNT) begin
                        state_nxt   = IDLE;
                        clr_cnt_nxt = '0;
                        clr_last    = 1'b1;
                    end else begin
                        clr_cnt_nxt = clr_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            last_gnt <= GNT_LDR;
        end else begin
            state    <= state_nxt;
            clr_cnt  <= clr_cnt_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Read data is captured once at the end of a granted read and held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q         <= '0;
            wdata_q        <= '0;
            bus.rdata      <= '0;
            bus.cpu_rvalid <= 1'b0;
            bus.ldr_rvalid <= 1'b0;
            bus.clr_done   <= 1'b0;
        end else begin
            addr_q         <= mem_addr_c;
            wdata_q        <= mem_wdata_c;
            if ((cpu_sel && !bus.cpu_we) || (ldr_sel && !bus.ldr_we))
                bus.rdata  <= bus.mem_rdata;
            bus.cpu_rvalid <= cpu_sel && !bus.cpu_we;
            bus.ldr_rvalid <= ldr_sel && !bus.ldr_we;
            bus.clr_done   <= clr_last;
        end
    end

    assign bus.cpu_gnt   = cpu_sel;
    assign bus.ldr_gnt   = ldr_sel;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.mem_wen   = mem_wen_c;
    assign bus.clr_busy  = (state == CLEAR) && !rst;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a word-level model of the RAM,
// the arbitration rule and the clear sweep.
module tb_dmem_arbiter;
    logic clk;
    logic rst;

    dmem_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(11), .DATA_W(32), .DEPTH(2048)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: asynchronous read, write on posedge when wen is high.
    logic [31:0] ram [2048];
    always @(posedge clk) if (bus.mem_wen) ram[bus.mem_addr] <= bus.mem_wdata;
    assign bus.mem_rdata = ram[bus.mem_addr];

    int checkCount = 0;
    int errorCount = 0;
    int busyCycles = 0;
    int doneCount  = 0;

    always @(negedge clk) begin
        if (bus.clr_busy === 1'b1) busyCycles++;
        if (bus.clr_done === 1'b1) doneCount++;
    end

    // Reference model state
    logic [31:0] refMem [2048];
    bit          mInit = 0;
    bit          mBusy = 0;
    int          mPos  = 0;
    int          mLast = 1;
    logic [31:0] mRdata;
    bit          mCpuRv, mLdrRv, mDone;
    logic [10:0] mAddr;
    logic [31:0] mWdata;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit cs,
                                 input bit cr, input bit cw, input logic [10:0] ca, input logic [31:0] cd,
                                 input bit lr, input bit lw, input logic [10:0] la, input logic [31:0] ld);
        bit          egC, egL, eWen, eBusy;
        logic [10:0] eAddr;
        logic [31:0] eWd;
        rst           = r;
        bus.clr_start = cs;
        bus.cpu_req   = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.ldr_req   = lr; bus.ldr_we = lw; bus.ldr_addr = la; bus.ldr_wdata = ld;
        @(negedge clk);
        egC = 0; egL = 0; eWen = 0; eBusy = 0;
        eAddr = mAddr; eWd = mWdata;
        if (r) begin
            eAddr = '0; eWd = '0;
        end else if (mBusy) begin
            eBusy = 1; eWen = 1; eAddr = 11'(mPos); eWd = '0;
        end else if (!cs) begin
            if (cr && lr) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
                egC = 1;
`else
                egC = (mLast == 1);
                egL = !egC;
`endif
            end else begin
                egC = cr; egL = lr;
            end
            if (egC) begin eAddr = ca; eWd = cd; eWen = cw; end
            if (egL) begin eAddr = la; eWd = ld; eWen = lw; end
        end
        checkOutput("cpu_gnt", 32'(bus.cpu_gnt), 32'(egC));
        checkOutput("ldr_gnt", 32'(bus.ldr_gnt), 32'(egL));
        checkOutput("mem_wen", 32'(bus.mem_wen), 32'(eWen));
        checkOutput("clr_busy", 32'(bus.clr_busy), 32'(eBusy));
        checkOutput("mem_addr", 32'(bus.mem_addr), 32'(eAddr));
        checkOutput("mem_wdata", bus.mem_wdata, eWd);
        if (mInit) begin
            checkOutput("clr_done", 32'(bus.clr_done), 32'(mDone));
            checkOutput("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(mCpuRv));
            checkOutput("ldr_rvalid", 32'(bus.ldr_rvalid), 32'(mLdrRv));
            checkOutput("rdata", bus.rdata, mRdata);
        end
        @(posedge clk);
        if (r) begin
            mInit = 1; mBusy = 0; mPos = 0; mLast = 1;
            mRdata = '0; mCpuRv = 0; mLdrRv = 0; mDone = 0;
            mAddr = '0; mWdata = '0;
        end else begin
            mCpuRv = egC && !cw;
            mLdrRv = egL && !lw;
            if (mCpuRv || mLdrRv) mRdata = refMem[eAddr];
            if (eWen) refMem[eAddr] = eWd;
            mDone = mBusy && (mPos == 2047);
            if (mBusy) begin
                if (mPos == 2047) begin mBusy = 0; mPos = 0; end
                else mPos++;
            end else if (cs) begin
                mBusy = 1; mPos = 0;
            end
            if (egC) mLast = 0;
            if (egL) mLast = 1;
            mAddr = eAddr; mWdata = eWd;
        end
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    // Start a clear, optionally pulse clr_start again or reset partway through, then check its length.
    task automatic runClear(input int secondAt, input int abortAt, input bit cpuHold);
        int expLen;
        expLen = (abortAt >= 0) ? abortAt : 2048;
        busyCycles = 0;
        doneCount  = 0;
        applyStimulus(0, 1, cpuHold, 0, 11'd0, '0, 0, 0, '0, '0);
        for (int i = 0; i < 2100; i++) begin
            if (i == abortAt) begin
                applyStimulus(1, 0, cpuHold, 0, 11'd0, '0, 0, 0, '0, '0);
                break;
            end
            applyStimulus(0, i == secondAt, cpuHold, 0, 11'd0, '0, 0, 0, '0, '0);
            if (!mBusy) break;
        end
        applyStimulus(0, 0, cpuHold, 0, 11'd0, '0, 0, 0, '0, '0);
        idleCycle();
        idleCycle();
        checkOutput("clr_len", 32'(busyCycles), 32'(expLen));
        checkOutput("clr_done_count", 32'(doneCount), (abortAt >= 0) ? 32'd0 : 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        $display("[TB] start");
        for (int i = 0; i < 2048; i++) begin
            v = $urandom;
            ram[i]    = v;
            refMem[i] = v;
        end
        applyStimulus(1, 0, 1, 1, 11'd3, 32'h1, 1, 1, 11'd4, 32'h2);
        applyStimulus(1, 0, 1, 1, 11'd3, 32'h1, 1, 1, 11'd4, 32'h2);
        idleCycle();

        applyStimulus(0, 0, 1, 1, 11'd5, 32'hDEADBEEF, 0, 0, '0, '0);
        applyStimulus(0, 0, 1, 0, 11'd5, '0, 0, 0, '0, '0);
        idleCycle();
        idleCycle();

        for (int i = 0; i < 4; i++)
            applyStimulus(0, 0, 1, 0, 11'd5, '0, 1, 0, 11'd6, '0);
        idleCycle();

        for (int i = 0; i < 300; i++) begin
            logic [10:0] ca, la;
            ca = ($urandom_range(0, 7) == 0) ? 11'd2047 : 11'($urandom_range(0, 15));
            la = ($urandom_range(0, 7) == 0) ? 11'd2047 : 11'($urandom_range(0, 15));
            applyStimulus(0, 0, 1'($urandom), 1'($urandom), ca, $urandom,
                          1'($urandom), 1'($urandom), la, $urandom);
        end
        idleCycle();

        applyStimulus(0, 0, 0, 0, '0, '0, 1, 1, 11'd0, 32'h12);
        applyStimulus(0, 0, 0, 0, '0, '0, 1, 1, 11'd2047, 32'h34);
        runClear(-1, -1, 1);
        applyStimulus(0, 0, 0, 0, '0, '0, 1, 0, 11'd2047, '0);
        idleCycle();

        runClear(10, -1, 0);

        applyStimulus(0, 0, 1, 1, 11'd200, 32'hA5A5A5A5, 0, 0, '0, '0);
        applyStimulus(0, 0, 0, 0, '0, '0, 1, 1, 11'd50, 32'h5A5A5A5A);
        runClear(-1, 100, 0);
        applyStimulus(0, 0, 1, 0, 11'd50, '0, 1, 0, 11'd200, '0);
        applyStimulus(0, 0, 0, 0, '0, '0, 1, 0, 11'd200, '0);
        idleCycle();
        runClear(-1, -1, 0);

        applyStimulus(0, 0, 1, 0, 11'd0, '0, 1, 0, 11'd2047, '0);
        applyStimulus(0, 0, 1, 0, 11'd0, '0, 1, 0, 11'd2047, '0);
        applyStimulus(0, 0, 1, 0, 11'd200, '0, 0, 0, '0, '0);
        idleCycle();
        idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
